// File: rtl/shfl_seq_pkg.sv
// Shared types for the shift-to-first-one sequencer.
// Holds the data and shift-amount widths and the FSM state encoding.
// Imported by the interface and the sequencer.
package shfl_seq_pkg;
   localparam int DATA_W  = 16;
   localparam int SHAMT_W = $clog2(DATA_W) + 1;

   typedef logic [DATA_W-1:0]  t_data;
   typedef logic [SHAMT_W-1:0] t_shamt;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } t_shfl_state;
endpackage

// File: rtl/shfl_seq_if.sv
// Request/response bundle for shfl_seq: operation offer in, result out.
// Latency: none, wires only.
// Backpressure: valid/ready on both the start and result sides.
interface shfl_seq_if;
   import shfl_seq_pkg::*;

   logic   start_valid;
   logic   start_ready;
   t_data  A;
   t_data  B;
   logic   res_valid;
   logic   res_ready;
   t_data  result;
   t_shamt shamt;
   logic   ovf;

   // requester side: offers operands, consumes the result
   modport master (
      output start_valid, A, B, res_ready,
      input  start_ready, res_valid, result, shamt, ovf
   );

   // sequencer side
   modport slave (
      input  start_valid, A, B, res_ready,
      output start_ready, res_valid, result, shamt, ovf
   );
endinterface

// File: rtl/shfl_seq.sv
// Shifts A left by one more than the index of B's lowest set bit, one bit per cycle.
// Latency: tz(B)+2 cycles from acceptance to res_valid (1 cycle when B==0).
// Backpressure: result held in DONE until res_ready; start_ready only in IDLE.
module shfl_seq #(
   parameter int DATA_W = shfl_seq_pkg::DATA_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   output logic        busy,
   shfl_seq_if.slave   bus
);
   import shfl_seq_pkg::*;

   t_shfl_state state;
   t_shfl_state state_nxt;
   t_data       acc;
   t_data       breg;
   t_shamt      cnt;
   logic        ovf_q;
   logic        accept;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state, handshakes and status outputs
   always_comb begin
      state_nxt       = state;
      bus.start_ready = (state == IDLE);
      bus.res_valid   = (state == DONE);
      busy            = (state != IDLE);
      accept          = bus.start_valid && (state == IDLE) && !flush;
      case (state)
         IDLE: if (accept) state_nxt = (bus.B != '0) ? RUN : DONE;
         RUN:  if (breg[0]) state_nxt = DONE;
         DONE: if (bus.res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // flush abandons whatever is in flight, including an unconsumed result
      if (flush) state_nxt = IDLE;
   end

   // datapath: latch operands on acceptance, then one shift/scan step per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         breg  <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         acc   <= bus.A;
         breg  <= bus.B;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else if (state == RUN && !flush) begin
         acc   <= {acc[DATA_W-2:0], 1'b0};
         ovf_q <= ovf_q | acc[DATA_W-1];
         cnt   <= cnt + t_shamt'(1);
         // breg is only consulted while RUN continues, so shifting on the last step is harmless
         breg  <= {1'b0, breg[DATA_W-1:1]};
      end
   end

   // result bus reflects the accumulator directly
   always_comb begin
      bus.result = acc;
      bus.shamt  = cnt;
      bus.ovf    = ovf_q;
   end
endmodule

// File: tb/tb_shfl_seq.sv
// Randomised scoreboard bench for shfl_seq with directed corner cases.
// Stimulus pushes expectations; a negedge monitor drives res_ready and checks.
// Flush and reset scenarios are checked directly against reset-state values.
module tb_shfl_seq;
   import shfl_seq_pkg::*;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  sh;
      logic        ov;
      int          vcyc;
      int          hold;
   } exp_t;

   logic clk;
   logic rst;
   logic flush;
   logic busy;
   int   cyc;
   int   tests;
   int   fails;
   exp_t sbq[$];

   shfl_seq_if bus ();

   shfl_seq #(.DATA_W(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .busy  (busy),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // reference: shift by (index of lowest one)+1, computed on a double-width word
   task automatic ref_model(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] res, output logic [4:0] sh,
                            output logic ov, output int lat);
      int tz;
      logic [31:0] full;
      if (b == 16'h0) begin
         res = a; sh = 5'd0; ov = 1'b0; lat = 0;
      end else begin
         tz = 0;
         while (b[tz] == 1'b0) tz++;
         full = {16'h0, a} << (tz + 1);
         res  = full[15:0];
         ov   = |full[31:16];
         sh   = 5'(tz + 1);
         lat  = tz + 1;
      end
   endtask

   // monitor: owns res_ready, compares every cycle the result is presented
   bit seen;
   int hold_cnt;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.res_valid) begin
            if (sbq.size() == 0) begin
               chk("spurious_res_valid", 1, 0);
            end else begin
               e = sbq[0];
               if (!seen) begin
                  chk("latency", cyc, e.vcyc);
                  seen     = 1'b1;
                  hold_cnt = e.hold;
               end
               chk("result", int'(bus.result), int'(e.res));
               chk("shamt", int'(bus.shamt), int'(e.sh));
               chk("ovf", int'(bus.ovf), int'(e.ov));
               chk("start_ready_in_done", int'(bus.start_ready), 0);
               chk("busy_in_done", int'(busy), 1);
            end
         end
         if (hold_cnt > 0) begin
            bus.res_ready = 1'b0;
            hold_cnt--;
         end else begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
         end
         if (bus.res_valid && bus.res_ready && sbq.size() != 0) begin
            void'(sbq.pop_front());
            seen = 1'b0;
         end
      end
   end

   // offer one operation starting at a negedge; returns at a negedge after acceptance
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit track, input int hold);
      exp_t e;
      int lat;
      bit ok;
      ok = 1'b0;
      bus.A = a;
      bus.B = b;
      bus.start_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (bus.start_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
         bus.start_valid = 1'b0;
         return;
      end
      if (track) begin
         ref_model(a, b, e.res, e.sh, e.ov, lat);
         e.vcyc = cyc + 1 + lat;
         e.hold = hold;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && sbq.size() != 0; i++) @(negedge clk);
      chk("drain_queue_empty", sbq.size(), 0);
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_start_ready"}, int'(bus.start_ready), 1);
      chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      cyc = 0; tests = 0; fails = 0; seen = 1'b0; hold_cnt = 0;
      rst = 1'b1; flush = 1'b0;
      bus.start_valid = 1'b0; bus.A = '0; bus.B = '0; bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_reset("reset");
      chk("reset_result", int'(bus.result), 0);
      chk("reset_shamt", int'(bus.shamt), 0);
      chk("reset_ovf", int'(bus.ovf), 0);
      rst = 1'b0;
      @(negedge clk);

      // directed corner cases
      do_op(16'h0003, 16'h0004, 1'b1, 0);
      do_op(16'h1234, 16'h0000, 1'b1, 0);
      do_op(16'hFFFF, 16'h8000, 1'b1, 0);
      do_op(16'h8001, 16'h0001, 1'b1, 5);
      drain();

      // randomised operations, lowest set bit spread across all positions
      for (int n = 0; n < 60; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom) & (16'hFFFF << $urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) rb = 16'h0;
         do_op(ra, rb, 1'b1, $urandom_range(0, 2));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      // flush mid-RUN: no result, back to IDLE next cycle
      do_op(16'h00FF, 16'h0100, 1'b0, 0);
      repeat (2) @(negedge clk);
      chk("run_busy_before_flush", int'(busy), 1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk_idle_reset("after_flush");
      repeat (12) @(negedge clk);
      do_op(16'h0001, 16'h0002, 1'b1, 0);
      drain();

      // reset mid-RUN with a competing start offer
      do_op(16'hFFFF, 16'h8000, 1'b0, 0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      bus.start_valid = 1'b1; bus.A = 16'h0005; bus.B = 16'h0000;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.start_valid = 1'b0;
      @(negedge clk);
      chk_idle_reset("after_rst");
      chk("after_rst_result", int'(bus.result), 0);
      chk("after_rst_shamt", int'(bus.shamt), 0);
      chk("after_rst_ovf", int'(bus.ovf), 0);
      @(negedge clk);
      chk("after_rst_not_accepted", int'(busy), 0);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/shfl_seq.md
SHFL_SEQ -- requirements
Module: shfl_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the data bus width and equal to the width of t_data.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port flush, input, 1 bit: pipeline flush that abandons the current operation.
REQ-005 SHALL have port start_valid, input, 1 bit: requester offers an operation.
REQ-006 SHALL have port start_ready, output, 1 bit: sequencer can accept an operation.
REQ-007 SHALL have port A, input, t_data: operand to be shifted.
REQ-008 SHALL have port B, input, t_data: shift-amount operand.
REQ-009 SHALL have port res_valid, output, 1 bit: result, shamt and ovf are valid.
REQ-010 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result, output, t_data: shifted value.
REQ-012 SHALL have port shamt, output, t_shamt ($clog2(DATA_W)+1 bits): total shift applied.
REQ-013 SHALL have port ovf, output, 1 bit: at least one '1' was shifted out of result.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL compute result = A << (tz(B)+1), where tz(B) is the index of the least significant '1' of B; if B==0, result = A and shamt = 0.
REQ-016 SHALL implement FSM states IDLE, RUN and DONE, encoded as t_shfl_state.
REQ-017 SHALL drive start_ready = 1 only in IDLE; an operation is accepted on an edge where start_valid && start_ready && !flush.
REQ-018 SHALL, on acceptance, latch A into acc and B into breg, clear cnt and ovf, then go to RUN if B!=0 or to DONE if B==0.
REQ-019 SHALL, in each RUN cycle: shift acc left by 1 with zero fill; OR the old acc[DATA_W-1] into ovf; increment cnt.
REQ-020 SHALL, in each RUN cycle, go to DONE if breg[0]==1, otherwise shift breg right by 1 and stay in RUN.
REQ-021 SHALL spend exactly tz(B)+1 cycles in RUN; for acceptance in cycle n, res_valid is high from cycle n+tz(B)+2 (n+1 when B==0).
REQ-022 SHALL hold res_valid high and result, shamt, ovf stable in DONE until res_ready is high at an edge, then go to IDLE.
REQ-023 SHALL drive result = acc and shamt = cnt; cnt never exceeds DATA_W.
REQ-024 SHALL give result = 0 and shamt = DATA_W for B with only bit DATA_W-1 set; ovf is then the OR of all bits of A.
REQ-025 SHALL, when flush is high at an edge, go to IDLE from any state, drop any pending result and accept nothing in that cycle.
REQ-026 SHALL ignore A and B changes after acceptance.
REQ-027 SHALL hold res_valid low outside DONE.
REQ-028 SHALL not accept a new operation in the same cycle as a DONE handshake.

Reset
REQ-029 SHALL, when rst is high at an edge, set state = IDLE and clear acc, breg, cnt and ovf.
REQ-030 SHALL drive outputs after reset as: start_ready = 1, res_valid = 0, busy = 0, result = 0, shamt = 0, ovf = 0.
REQ-031 SHALL give rst priority over flush and over any handshake, including when rst occurs mid-RUN.

Structure
REQ-032 SHALL take t_data, DATA_W, t_shamt and t_shfl_state from the shared processor package.
REQ-033 SHALL be a single module with no sub-modules; the one-bit-per-cycle shift and scan are done inline.

Verification (DATA_W = 16)
REQ-034 SHALL cover: A=0x0003, B=0x0004 -> res_valid in cycle n+4, result=0x0018, shamt=3, ovf=0.
REQ-035 SHALL cover: A=0x1234, B=0x0000 -> res_valid in cycle n+1, result=0x1234, shamt=0, ovf=0.
REQ-036 SHALL cover: A=0xFFFF, B=0x8000 -> 16 RUN cycles, result=0x0000, shamt=16, ovf=1.
REQ-037 SHALL cover: A=0x8001, B=0x0001 -> result=0x0002, shamt=1, ovf=1; res_ready held low 5 cycles -> outputs stable and start_ready=0 throughout.
REQ-038 SHALL cover: flush during RUN of B=0x0100 -> IDLE next cycle, res_valid never rises; the following op A=1, B=2 -> result=0x0004.
REQ-039 SHALL cover: rst pulsed mid-RUN -> all outputs at reset values the next cycle; start_valid during the rst cycle is not accepted.
